mips_mul_div_unit: RTL and testbench
====================================

# mips_mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath. It sits directly downstream of the 32x32 register file and consumes the S and T read ports as operands. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle sequence and holds the 64-bit result in internal HI/LO registers for MFHI/MFLO. A start/busy/done handshake lets the pipeline controller stall while the unit computes.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- S  input  32  operand A (multiplicand / dividend), from register-file port S.
- T  input  32  operand B (multiplier / divisor), from register-file port T.
- busy  output  1  high while an operation is in progress (CALC, FIX).
- done  output  1  single-cycle completion pulse (DONE state).
- div_by_zero  output  1  valid with done; high if a DIV/DIVU had T==0.
- hi  output  32  HI register: upper product word, or remainder.
- lo  output  32  LO register: lower product word, or quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1: capture S, T, op. For signed ops, store magnitudes plus sign flags. Clear count to 0, then go to CALC. Without start, DONE goes to IDLE.
- DIV/DIVU with T==0 at capture: go straight to DONE with div_by_zero=1. HI/LO are left unchanged.
- CALC: one iteration per edge. Multiply is shift-add on the 64-bit accumulator. Divide is restoring shift-subtract on the 32-bit partial remainder.
- CALC: the count increments each iteration. After the 32nd iteration (count==31), go to FIX.
- FIX: apply the sign correction, write hi/lo, then go to DONE.
- Signed multiply: the 64-bit product is negated if the operand signs differ.
- Signed divide: quotient truncates toward zero and is negated if the operand signs differ. The remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0x00000000. No trap.
- S/T changes after the capture edge have no effect. start while busy=1 is ignored.
- hi/lo hold their values until the next FIX or reset. div_by_zero is cleared on every accepted start.

## Timing
- Reset (asynchronous): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, count=0.
- Start sampled at edge N:
  - busy goes high after edge N.
  - CALC iterations occur at edges N+1 through N+32.
  - FIX happens at edge N+33, where hi/lo are updated and busy drops.
  - done is high for exactly the one cycle after edge N+33.
- Divide-by-zero: done and div_by_zero are high in the cycle after edge N. busy never asserts.
- Back-to-back: a start during the done cycle is accepted at that edge. Throughput is one operation per 34 cycles.
- Reset asserted mid-operation aborts immediately: no done pulse, and hi/lo are cleared.

## Configuration
- MDU_DIV_EN defined: full behaviour as above.
- MDU_DIV_EN undefined:
  - The divider datapath is compiled out.
  - start with op[1]=1 is ignored: state stays IDLE/DONE→IDLE, with no busy and no done.
  - div_by_zero is tied to 0.
  - MULT/MULTU behaviour and timing are unchanged.

## Test plan
- MULTU S=0xFFFFFFFF, T=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done is exactly 33 edges after start, and busy is high for 33 cycles.
- MULT S=0xFFFFFFFD (-3), T=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV S=0xFFFFFFF9 (-7), T=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU S=100, T=0 -> done and div_by_zero in the cycle after the start edge; hi/lo keep the previous values. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Toggle S/T and pulse start during CALC -> result matches the originally captured operands, and no second operation starts.
- Assert reset at iteration 10 -> busy=0, done=0, hi=lo=0 immediately, with no done pulse afterward. With MDU_DIV_EN undefined, a DIV start produces no busy or done.

Source files
------------

// File: rtl/mips_mul_div_unit.sv
// ---------------------------------------------------------------------------
// mips_mul_div_unit
//
// Iterative 32-bit multiply/divide unit for the MIPS datapath. Operands come
// straight from the register-file S and T read ports. MULT/MULTU/DIV/DIVU run
// over a fixed 32-iteration sequence. The 64-bit result is kept in HI/LO for
// MFHI/MFLO.
//
// Sequence for an accepted start at edge N:
//   edges N+1..N+32  CALC, one shift-add or shift-subtract step per edge
//   edge  N+33       FIX, sign correction and HI/LO write
//   next cycle       DONE, single-cycle done pulse
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   request; only sampled in IDLE or DONE
//   op           in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   S            in   32  multiplicand / dividend
//   T            in   32  multiplier / divisor
//   busy         out  1   high in CALC and FIX
//   done         out  1   high for the one DONE cycle
//   div_by_zero  out  1   valid with done; DIV/DIVU issued with T == 0
//   hi           out  32  upper product word, or remainder
//   lo           out  32  lower product word, or quotient
//
// Build option
//   MDU_DIV_EN   when defined, the divider is built. When undefined, DIV/DIVU
//                starts are ignored and div_by_zero is tied low. Multiply
//                behaviour and timing are identical in both builds.
// ---------------------------------------------------------------------------
module mips_mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] S,
    input  logic [31:0] T,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_count;
    // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
    logic [63:0] r_acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [31:0] r_a;
    // Negate the 64-bit product (multiply) or the quotient (divide).
    logic        r_neg_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic        w_ready;
    logic        w_accept;
    logic        w_go_done;
    logic        w_is_div;
    logic        w_signed;
    logic        w_s_neg;
    logic        w_t_neg;
    logic [31:0] w_s_mag;
    logic [31:0] w_t_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_iter_next;
    logic [63:0] w_prod;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;

`ifdef MDU_DIV_EN
    logic        r_is_div;
    logic        r_neg_hi;
    logic        r_dbz;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
`endif

    // ------------------------------------------------------------------
    // Start acceptance
    // ------------------------------------------------------------------
    assign w_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);

`ifdef MDU_DIV_EN
    assign w_is_div  = op[1];
    assign w_accept  = w_ready && start;
    // Divide by zero skips the datapath entirely and reports at once.
    assign w_go_done = w_accept && w_is_div && (T == 32'd0);
`else
    // Without a divider, DIV/DIVU requests are dropped as if start were low.
    assign w_is_div  = 1'b0;
    assign w_accept  = w_ready && start && !op[1];
    assign w_go_done = 1'b0;
`endif

    // MULT (00) and DIV (10) are the signed forms.
    assign w_signed = ~op[0];
    assign w_s_neg  = w_signed & S[31];
    assign w_t_neg  = w_signed & T[31];
    // The magnitude of 0x80000000 is 0x80000000 read as unsigned, which keeps
    // the most negative operand exact.
    assign w_s_mag  = w_s_neg ? (~S + 32'd1) : S;
    assign w_t_mag  = w_t_neg ? (~T + 32'd1) : T;

    // ------------------------------------------------------------------
    // Multiply step: add the multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right. The
    // 33-bit sum keeps the carry, which becomes the new MSB.
    // ------------------------------------------------------------------
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_a};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[31:1]}
                                 : {1'b0, r_acc[63:1]};

`ifdef MDU_DIV_EN
    // ------------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the remainder.
    // Subtract the divisor if it fits, and shift the result bit into the
    // quotient. The remainder is always below the divisor, so the shifted
    // value fits in 33 bits. A successful difference fits in 32 bits.
    // ------------------------------------------------------------------
    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_a});
    assign w_div_diff  = w_div_shift[31:0] - r_a;
    assign w_div_next  = w_div_ge ? {w_div_diff,        r_acc[30:0], 1'b1}
                                  : {w_div_shift[31:0], r_acc[30:0], 1'b0};

    assign w_iter_next = r_is_div ? w_div_next : w_mul_next;

    // Quotient truncates toward zero. The remainder follows the dividend sign.
    assign w_quot = r_neg_lo ? (~r_acc[31:0]  + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_hi ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
`else
    assign w_iter_next = w_mul_next;
`endif

    assign w_prod = r_neg_lo ? (~r_acc + 64'd1) : r_acc;

`ifdef MDU_DIV_EN
    assign w_hi_fix = r_is_div ? w_rem  : w_prod[63:32];
    assign w_lo_fix = r_is_div ? w_quot : w_prod[31:0];
`else
    assign w_hi_fix = w_prod[63:32];
    assign w_lo_fix = w_prod[31:0];
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every
            // register samples the pre-edge values, independent of block order.
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational;
        // a path that leaves the target unassigned would infer a latch.
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_next = w_go_done ? ST_DONE : ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_count == 5'd31) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 5'd0;
            r_acc    <= 64'd0;
            r_a      <= 32'd0;
            r_neg_lo <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (w_accept) begin
            // Operands are captured here, so later changes on S/T are ignored.
            r_count  <= 5'd0;
            r_a      <= w_is_div ? w_t_mag : w_s_mag;
            r_acc    <= {32'd0, (w_is_div ? w_s_mag : w_t_mag)};
            r_neg_lo <= w_s_neg ^ w_t_neg;
        end else if (r_state == ST_CALC) begin
            r_count  <= r_count + 5'd1;
            r_acc    <= w_iter_next;
        end else if (r_state == ST_FIX) begin
            r_hi     <= w_hi_fix;
            r_lo     <= w_lo_fix;
        end
    end

`ifdef MDU_DIV_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_is_div <= w_is_div;
            r_neg_hi <= w_s_neg;
            // Every accepted start clears the flag unless this start is the zero divide.
            r_dbz    <= w_go_done;
        end
    end

    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign done = (r_state == ST_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_mul_div_unit
//
// Directed bench for mips_mul_div_unit. Inputs change on the falling edge.
// Outputs are sampled on the falling edge, half a cycle away from the active
// rising edge. Divide vectors are exercised when MDU_DIV_EN is defined.
// Otherwise the bench confirms that divide requests are ignored.
// ---------------------------------------------------------------------------
module tb_mips_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] S;
    logic [31:0] T;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
`ifdef MDU_DIV_EN
    localparam logic [1:0] OP_DIVU  = 2'b11;
`endif

    mips_mul_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .S           (S),
        .T           (T),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Must be called on a falling edge. Returns on the falling edge after the
    // capture edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        op    = o;
        S     = a;
        T     = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done is seen, bounded at 100 edges.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int bcyc;
    int n_done;
    int n_busy;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        S     = 32'd0;
        T     = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz",  div_by_zero, 0);
        check("reset_hi",   hi, 0);
        check("reset_lo",   lo, 0);

        // MULTU max * max, with exact latency and busy length
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        check("multu_latency", lat, 33);
        check("multu_busy_cycles", bcyc, 33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_dbz", div_by_zero, 0);
        @(negedge clk);
        check("multu_done_one_cycle", done, 0);

        // MULT -3 * 7
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(lat, bcyc);
        check("mult_neg_latency", lat, 33);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);

`ifdef MDU_DIV_EN
        // Back-to-back DIV -7 / 2, started in the done cycle
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check("b2b_accepted_busy", busy, 1);
        wait_done(lat, bcyc);
        check("div_neg_latency", lat, 33);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
`else
        // Divider absent: a DIV start from the done cycle is dropped
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check("nodiv_busy", busy, 0);
        check("nodiv_done", done, 0);
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        check("nodiv_no_done_later", n_done, 0);
        check("nodiv_no_busy_later", n_busy, 0);
        check("nodiv_dbz", div_by_zero, 0);
        check("nodiv_hi_kept", hi, 32'hFFFF_FFFF);
        check("nodiv_lo_kept", lo, 32'hFFFF_FFEB);
`endif

        // MULT most-negative squared: 2^62
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bcyc);
        check("mult_minsq_hi", hi, 32'h4000_0000);
        check("mult_minsq_lo", lo, 32'h0000_0000);

        // MULT 5 * -1
        issue(OP_MULT, 32'h0000_0005, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        check("mult_m1_hi", hi, 32'hFFFF_FFFF);
        check("mult_m1_lo", lo, 32'hFFFF_FFFB);

`ifdef MDU_DIV_EN
        // DIVU by zero reports in the next cycle. HI/LO are unchanged.
        issue(OP_DIVU, 32'd100, 32'd0);
        check("dbz_done", done, 1);
        check("dbz_flag", div_by_zero, 1);
        check("dbz_busy", busy, 0);
        check("dbz_hi_kept", hi, 32'hFFFF_FFFF);
        check("dbz_lo_kept", lo, 32'hFFFF_FFFB);
        @(negedge clk);
        check("dbz_done_one_cycle", done, 0);

        // DIV overflow case, no trap
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);
        check("div_ovf_dbz_cleared", div_by_zero, 0);

        // DIVU 100 / 7
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, bcyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // DIV 7 / -2: remainder follows the dividend sign
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, bcyc);
        check("div_rem_sign_lo", lo, 32'hFFFF_FFFD);
        check("div_rem_sign_hi", hi, 32'h0000_0001);
`endif

        // Operand and start activity during CALC must be ignored
        @(negedge clk);
        issue(OP_MULTU, 32'h1234_5678, 32'h0000_0010);
        for (int i = 0; i < 5; i++) begin
            S     = $urandom;
            T     = $urandom;
            op    = OP_MULT;
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(lat, bcyc);
        check("toggle_latency", lat, 28);
        check("toggle_hi", hi, 32'h0000_0001);
        check("toggle_lo", lo, 32'h2345_6780);
        @(negedge clk);
        check("toggle_no_second_op", busy, 0);

        // Reset mid-operation at iteration 10
        issue(OP_MULTU, 32'h0000_00FF, 32'h0000_0003);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done_pulse", n_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not complete");
    end

endmodule
